// File: rtl/ex_mem_skid.sv
// Execute-to-memory boundary: two-entry skid register.
// in_ready depends only on registered state, so ALU-side timing is isolated from memory stalls.
module ex_mem_skid #(
    parameter int XLEN = 64,
    parameter int RDW  = 5,
    parameter int OPW  = 4,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            stall_e,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_sdata,
    input  logic [RDW-1:0]  in_rd,
    input  logic            in_wen,
    input  logic [OPW-1:0]  in_memop,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_sdata,
    output logic [RDW-1:0]  out_rd,
    output logic            out_wen,
    output logic [OPW-1:0]  out_memop,
    output logic [1:0]      occupancy,
    output logic [CNTW-1:0] stall_cycles
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] sdata;
        logic [RDW-1:0]  rd;
        logic            wen;
        logic [OPW-1:0]  memop;
    } ent_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    ent_t   head;
    ent_t   skid;
    ent_t   in_ent;
    logic   in_fire;
    logic   out_fire;

    assign in_ent = '{
        pc:     in_pc,
        result: in_result,
        sdata:  in_sdata,
        rd:     in_rd,
        wen:    in_wen,
        memop:  in_memop
    };

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign in_fire   = in_valid & ~stall_e & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_pc     = head.pc;
    assign out_result = head.result;
    assign out_sdata  = head.sdata;
    assign out_rd     = head.rd;
    assign out_wen    = head.wen;
    assign out_memop  = head.memop;

    // Occupancy FSM with head/skid capture; flush empties but keeps contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state <= ONE;
                        head  <= in_ent;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head <= in_ent;
                    end else if (in_fire) begin
                        state <= FULL;
                        skid  <= in_ent;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state <= ONE;
                        head  <= skid;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Saturating count of cycles the ALU held a valid instruction while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (in_valid && stall_e && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
